// File: rtl/taillight_pkg.sv
// Shared encodings for the Thunderbird taillight bus: mode codes, group patterns,
// lamp bit positions and the monitor's sequence state.
package taillight_pkg;

  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_LEFT  = 2'd1;
  localparam logic [1:0] MODE_RIGHT = 2'd2;
  localparam logic [1:0] MODE_HAZ   = 2'd3;

  // A group lights outward from its innermost lamp.
  localparam logic [2:0] P0 = 3'b000;
  localparam logic [2:0] P1 = 3'b001;
  localparam logic [2:0] P2 = 3'b011;
  localparam logic [2:0] P3 = 3'b111;

  localparam int RA_IDX = 0;
  localparam int RC_IDX = 2;
  localparam int LA_IDX = 3;
  localparam int LC_IDX = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEFT  = 3'd1,
    ST_RIGHT = 3'd2,
    ST_HAZ   = 3'd3,
    ST_LOST  = 3'd4
  } state_t;

  typedef struct packed {
    state_t     st;
    logic [1:0] k;
    logic       legal;
  } cls_t;

endpackage

// File: rtl/taillight_seq_monitor_if.sv
// Lamp bus plus the monitor's decoded status; master drives lamps, slave is the monitor.
interface taillight_seq_monitor_if;
  import taillight_pkg::*;

  logic [5:0] lights;
  logic [1:0] mode;
  logic [1:0] step;
  logic       cycle_done;
  logic       seq_err;
  logic       timing_err;
  logic       err_sticky;

  modport master (
    output lights,
    input  mode, step, cycle_done, seq_err, timing_err, err_sticky
  );

  modport slave (
    input  lights,
    output mode, step, cycle_done, seq_err, timing_err, err_sticky
  );
endinterface

// File: rtl/taillight_gap_timer.sv
// Saturating cycle counter between lamp changes, with gap-window and stall detection.
module taillight_gap_timer #(
  parameter int MAX_COUNT = 1000,
  parameter int TOL       = 16,
  parameter int CNT_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic chg,
  output logic gap_bad,
  output logic stall
);
  import taillight_pkg::*;

  localparam logic [CNT_W:0]   GAP_MIN   = (CNT_W+1)'(MAX_COUNT - TOL);
  localparam logic [CNT_W:0]   GAP_MAX   = (CNT_W+1)'(MAX_COUNT + TOL);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(MAX_COUNT + TOL + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   gap;

  always_comb begin
    cnt_d = cnt_q;
    if (chg)          cnt_d = '0;
    else if (~&cnt_q) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A saturated count is an unknown, long gap: always out of window.
  always_comb begin
    gap     = {1'b0, cnt_q} + (CNT_W+1)'(1);
    gap_bad = chg && ((gap < GAP_MIN) || (gap > GAP_MAX) || (&cnt_q));
    stall   = !chg && (cnt_q == STALL_CNT);
  end

endmodule

// File: rtl/taillight_seq_monitor.sv
// Receive-side checker for the 6-lamp taillight bus: decodes mode/step and flags
// illegal pattern sequences and off-period step timing. All outputs registered.
module taillight_seq_monitor #(
  parameter int MAX_COUNT = 1000,
  parameter int TOL       = 16,
  parameter int CNT_W     = 16
) (
  input logic                    clk,
  input logic                    rst,
  taillight_seq_monitor_if.slave bus
);
  import taillight_pkg::*;

  logic [5:0] lights_q, lights_p;
  logic       chg, gap_bad, stall;
  state_t     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [1:0] mode_q, mode_d, step_q, step_d;
  logic       cycle_done_q, cycle_done_d, seq_err_q, seq_err_d;
  logic       timing_err_q, timing_err_d, err_sticky_q, err_sticky_d;
  logic [2:0] grp_l, grp_r, grp_act, grp_oth;
  cls_t       cls;

  function automatic logic [2:0] pattern(input logic [1:0] k);
    case (k)
      2'd0:    return P0;
      2'd1:    return P1;
      2'd2:    return P2;
      default: return P3;
    endcase
  endfunction

  // How a pattern would be entered from IDLE; anything else is unrecoverable.
  function automatic cls_t classify(input logic [2:0] l, input logic [2:0] r);
    cls_t c;
    c = '{st: ST_LOST, k: 2'd0, legal: 1'b0};
    if (l == P0 && r == P0)      c = '{st: ST_IDLE,  k: 2'd0, legal: 1'b1};
    else if (r == P0 && l == P1) c = '{st: ST_LEFT,  k: 2'd1, legal: 1'b1};
    else if (l == P0 && r == P1) c = '{st: ST_RIGHT, k: 2'd1, legal: 1'b1};
    else if (l == P3 && r == P3) c = '{st: ST_HAZ,   k: 2'd3, legal: 1'b1};
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lights_q <= '0;
      lights_p <= '0;
    end else begin
      lights_q <= bus.lights;
      lights_p <= lights_q;
    end
  end

  assign chg = (lights_q != lights_p);

  taillight_gap_timer #(
    .MAX_COUNT (MAX_COUNT),
    .TOL       (TOL),
    .CNT_W     (CNT_W)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .chg     (chg),
    .gap_bad (gap_bad),
    .stall   (stall)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cycle_done_d = 1'b0;
    seq_err_d    = 1'b0;
    timing_err_d = 1'b0;
    grp_l        = lights_q[LC_IDX:LA_IDX];
    grp_r        = lights_q[RC_IDX:RA_IDX];
    grp_act      = (state_q == ST_RIGHT) ? grp_r : grp_l;
    grp_oth      = (state_q == ST_RIGHT) ? grp_l : grp_r;
    cls          = classify(grp_l, grp_r);

    case (state_q)
      ST_IDLE: begin
        if (chg) begin
          state_d   = cls.st;
          k_d       = cls.k;
          seq_err_d = !cls.legal;
        end
      end
      ST_LEFT, ST_RIGHT: begin
        if (chg) begin
          timing_err_d = gap_bad;
          if (grp_oth == P0 && k_q != 2'd3 && grp_act == pattern(2'(k_q + 2'd1))) begin
            k_d = 2'(k_q + 2'd1);
          end else if (grp_oth == P0 && grp_act == P0) begin
            state_d      = ST_IDLE;
            k_d          = 2'd0;
            cycle_done_d = (k_q == 2'd3);
          end else begin
            seq_err_d = 1'b1;
            state_d   = cls.st;
            k_d       = cls.k;
          end
        end else if (stall) begin
          timing_err_d = 1'b1;
          state_d      = ST_LOST;
          k_d          = 2'd0;
        end
      end
      ST_HAZ: begin
        if (chg) begin
          timing_err_d = gap_bad;
          if (lights_q == 6'b000000) begin
            state_d      = ST_IDLE;
            k_d          = 2'd0;
            cycle_done_d = 1'b1;
          end else begin
            seq_err_d = 1'b1;
            state_d   = cls.st;
            k_d       = cls.k;
          end
        end else if (stall) begin
          timing_err_d = 1'b1;
          state_d      = ST_LOST;
          k_d          = 2'd0;
        end
      end
      ST_LOST: begin
        if (lights_q == 6'b000000) begin
          state_d = ST_IDLE;
          k_d     = 2'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        k_d     = 2'd0;
      end
    endcase

    case (state_d)
      ST_LEFT:  mode_d = MODE_LEFT;
      ST_RIGHT: mode_d = MODE_RIGHT;
      ST_HAZ:   mode_d = MODE_HAZ;
      default:  mode_d = MODE_IDLE;
    endcase
    step_d       = (mode_d == MODE_IDLE) ? 2'd0 : k_d;
    err_sticky_d = err_sticky_q | seq_err_d | timing_err_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      k_q          <= 2'd0;
      mode_q       <= MODE_IDLE;
      step_q       <= 2'd0;
      cycle_done_q <= 1'b0;
      seq_err_q    <= 1'b0;
      timing_err_q <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      mode_q       <= mode_d;
      step_q       <= step_d;
      cycle_done_q <= cycle_done_d;
      seq_err_q    <= seq_err_d;
      timing_err_q <= timing_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.mode       = mode_q;
  assign bus.step       = step_q;
  assign bus.cycle_done = cycle_done_q;
  assign bus.seq_err    = seq_err_q;
  assign bus.timing_err = timing_err_q;
  assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_taillight_seq_monitor.sv
// Directed bench for taillight_seq_monitor with MAX_COUNT=20, TOL=2.
module tb_taillight_seq_monitor;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   n_done, n_seq, n_tim, n_both;
  int   b_done, b_seq, b_tim;

  taillight_seq_monitor_if tb_if ();

  taillight_seq_monitor #(
    .MAX_COUNT (20),
    .TOL       (2),
    .CNT_W     (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (tb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tallies, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      n_done = n_done + int'(tb_if.cycle_done);
      n_seq  = n_seq  + int'(tb_if.seq_err);
      n_tim  = n_tim  + int'(tb_if.timing_err);
      n_both = n_both + int'(tb_if.cycle_done & tb_if.seq_err);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Present a lamp pattern at a falling edge and hold it for n clocks.
  task automatic hold(input logic [5:0] pat, input int n);
    tb_if.lights = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_done = n_done;
    b_seq  = n_seq;
    b_tim  = n_tim;
  endtask

  task automatic check_deltas(input string tag, input int d_done, input int d_seq, input int d_tim);
    check_val({tag, "_done"}, n_done - b_done, d_done);
    check_val({tag, "_seq"},  n_seq  - b_seq,  d_seq);
    check_val({tag, "_tim"},  n_tim  - b_tim,  d_tim);
  endtask

  task automatic check_ms(input string tag, input logic [1:0] m, input logic [1:0] s);
    check_val({tag, "_mode"}, {30'd0, tb_if.mode}, {30'd0, m});
    check_val({tag, "_step"}, {30'd0, tb_if.step}, {30'd0, s});
  endtask

  function automatic logic [31:0] all_outs();
    return {24'd0, tb_if.mode, tb_if.step, tb_if.cycle_done, tb_if.seq_err,
            tb_if.timing_err, tb_if.err_sticky};
  endfunction

  initial begin
    checks = 0; failures = 0;
    n_done = 0; n_seq = 0; n_tim = 0; n_both = 0;
    b_done = 0; b_seq = 0; b_tim = 0;
    rst = 1'b1;
    tb_if.lights = 6'b000000;
    repeat (3) @(negedge clk);
    check_val("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_val("idle_outs", all_outs(), 32'd0);

    // Left cycle with nominal gaps
    snap();
    hold(6'b001000, 20); check_ms("t1_l1", 2'd1, 2'd1);
    hold(6'b011000, 20); check_ms("t1_l2", 2'd1, 2'd2);
    hold(6'b111000, 20); check_ms("t1_l3", 2'd1, 2'd3);
    hold(6'b000000, 20); check_ms("t1_idle", 2'd0, 2'd0);
    check_deltas("t1", 1, 0, 0);
    check_val("t1_sticky", {31'd0, tb_if.err_sticky}, 32'd0);

    // Hazard flashing
    snap();
    for (int i = 0; i < 2; i++) begin
      hold(6'b111111, 20); check_ms("t2_on", 2'd3, 2'd3);
      hold(6'b000000, 20); check_ms("t2_off", 2'd0, 2'd0);
    end
    check_deltas("t2", 2, 0, 0);
    check_val("t2_sticky", {31'd0, tb_if.err_sticky}, 32'd0);

    // Short gap then longest legal gap
    snap();
    hold(6'b001000, 17);
    hold(6'b011000, 22); check_ms("t3_l2", 2'd1, 2'd2);
    check_val("t3_tim_short", n_tim - b_tim, 32'd1);
    check_val("t3_sticky", {31'd0, tb_if.err_sticky}, 32'd1);
    hold(6'b111000, 20); check_ms("t3_l3", 2'd1, 2'd3);
    hold(6'b000000, 20);
    check_deltas("t3", 1, 0, 1);

    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_outs", all_outs(), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Illegal jump into the other group, recovery through all-off
    snap();
    hold(6'b001000, 20); check_ms("t4_l1", 2'd1, 2'd1);
    hold(6'b000011, 20); check_ms("t4_lost", 2'd0, 2'd0);
    check_val("t4_seq", n_seq - b_seq, 32'd1);
    hold(6'b000000, 5);
    hold(6'b001000, 20); check_ms("t4_relearn", 2'd1, 2'd1);
    hold(6'b000000, 20);
    check_deltas("t4", 0, 1, 0);
    check_val("t4_sticky", {31'd0, tb_if.err_sticky}, 32'd1);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Stall while LEFT/2 is held, then a clean abort
    snap();
    hold(6'b001000, 20);
    hold(6'b011000, 30); check_ms("t5_lost", 2'd0, 2'd0);
    check_deltas("t5_stall", 0, 0, 1);
    hold(6'b000000, 5);
    hold(6'b001000, 20); check_ms("t5_l1", 2'd1, 2'd1);
    hold(6'b000000, 20);
    check_deltas("t5", 0, 0, 1);
    check_val("t5_sticky", {31'd0, tb_if.err_sticky}, 32'd1);

    // Reset in the middle of a right sequence
    hold(6'b000001, 20); check_ms("t6_r1", 2'd2, 2'd1);
    hold(6'b000011, 5);  check_ms("t6_r2", 2'd2, 2'd2);
    rst = 1'b1;
    tb_if.lights = 6'b000001;
    #1;
    check_val("t6_async_rst", all_outs(), 32'd0);
    repeat (2) @(negedge clk);
    snap();
    rst = 1'b0;
    hold(6'b000001, 20); check_ms("t6_post_r1", 2'd2, 2'd1);
    hold(6'b000011, 20); check_ms("t6_post_r2", 2'd2, 2'd2);
    hold(6'b000111, 20); check_ms("t6_post_r3", 2'd2, 2'd3);
    hold(6'b000000, 20);
    check_deltas("t6", 1, 0, 0);
    check_val("t6_sticky", {31'd0, tb_if.err_sticky}, 32'd0);
    check_val("done_with_seq", n_both, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
